// File: rtl/alu_issue_stage.sv
// ID->EX issue register: decodes MIPS opcode/funct into an ALU op,
// selects the x/y operands and holds them in a one-entry handshake stage.
module alu_issue_stage #(
   parameter int unsigned XLEN       = 32,
   parameter logic [3:0]  ILLEGAL_OP = 4'b0010
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_rs_val,
   input  logic [XLEN-1:0] in_rt_val,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] alu_x,
   output logic [XLEN-1:0] alu_y,
   output logic [3:0]      alu_op,
   output logic [4:0]      out_rd,
   output logic            out_wen,
   output logic            out_illegal
);

   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_SRA  = 4'b1011;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_NOR  = 4'b0100;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLTU = 4'b0101;

   localparam logic [XLEN-1:0] LUI_SHIFT = XLEN'(16);

   logic [5:0]      opc;
   logic [5:0]      fn;
   logic [4:0]      rt_f;
   logic [4:0]      rd_f;
   logic [4:0]      shamt;
   logic [15:0]     imm;
   logic [XLEN-1:0] imm_sx;
   logic [XLEN-1:0] imm_zx;
   logic [XLEN-1:0] shamt_zx;
   logic [XLEN-1:0] rsamt_zx;

   assign opc   = in_instr[31:26];
   assign rt_f  = in_instr[20:16];
   assign rd_f  = in_instr[15:11];
   assign shamt = in_instr[10:6];
   assign fn    = in_instr[5:0];
   assign imm   = in_instr[15:0];

   assign imm_sx   = {{(XLEN-16){imm[15]}}, imm};
   assign imm_zx   = {{(XLEN-16){1'b0}}, imm};
   assign shamt_zx = {{(XLEN-5){1'b0}}, shamt};
   assign rsamt_zx = {{(XLEN-5){1'b0}}, in_rs_val[4:0]};

   // R-type funct decode
   logic       r_ok;
   logic       r_sh;
   logic       r_var;
   logic [3:0] r_op;

   always_comb begin
      r_ok  = 1'b1;
      r_sh  = 1'b0;
      r_var = 1'b0;
      r_op  = ILLEGAL_OP;
      unique case (fn)
         6'h00: begin r_op = OP_SLL; r_sh = 1'b1; end
         6'h02: begin r_op = OP_SRL; r_sh = 1'b1; end
         6'h03: begin r_op = OP_SRA; r_sh = 1'b1; end
         6'h04: begin r_op = OP_SLL; r_sh = 1'b1; r_var = 1'b1; end
         6'h06: begin r_op = OP_SRL; r_sh = 1'b1; r_var = 1'b1; end
         6'h07: begin r_op = OP_SRA; r_sh = 1'b1; r_var = 1'b1; end
         6'h20, 6'h21: r_op = OP_ADD;
         6'h22, 6'h23: r_op = OP_SUB;
         6'h24: r_op = OP_AND;
         6'h25: r_op = OP_OR;
         6'h26: r_op = OP_XOR;
         6'h27: r_op = OP_NOR;
         6'h2A: r_op = OP_SLT;
         6'h2B: r_op = OP_SLTU;
         default: r_ok = 1'b0;
      endcase
   end

   logic [XLEN-1:0] d_x;
   logic [XLEN-1:0] d_y;
   logic [3:0]      d_op;
   logic [4:0]      d_rd;
   logic            d_wen;
   logic            d_ill;

   // Defaults describe the undecodable case; legal encodings override.
   always_comb begin
      d_x   = in_rs_val;
      d_y   = in_rt_val;
      d_op  = ILLEGAL_OP;
      d_rd  = '0;
      d_wen = 1'b0;
      d_ill = 1'b1;
      unique case (opc)
         6'h00: begin
            if (r_ok) begin
               d_op  = r_op;
               d_ill = 1'b0;
               d_rd  = rd_f;
               d_wen = |rd_f;
               if (r_sh) begin
                  d_x = in_rt_val;
                  d_y = r_var ? rsamt_zx : shamt_zx;
               end
            end
         end
         6'h04, 6'h05: begin
            d_op  = OP_SUB;
            d_ill = 1'b0;
         end
         6'h08, 6'h09, 6'h23: begin
            d_op  = OP_ADD;
            d_y   = imm_sx;
            d_ill = 1'b0;
            d_rd  = rt_f;
            d_wen = |rt_f;
         end
         6'h0A: begin
            d_op  = OP_SLT;
            d_y   = imm_sx;
            d_ill = 1'b0;
            d_rd  = rt_f;
            d_wen = |rt_f;
         end
         6'h0B: begin
            d_op  = OP_SLTU;
            d_y   = imm_sx;
            d_ill = 1'b0;
            d_rd  = rt_f;
            d_wen = |rt_f;
         end
         6'h0C, 6'h0D, 6'h0E: begin
            d_op  = (opc[1:0] == 2'b00) ? OP_AND :
                    (opc[1:0] == 2'b01) ? OP_OR : OP_XOR;
            d_y   = imm_zx;
            d_ill = 1'b0;
            d_rd  = rt_f;
            d_wen = |rt_f;
         end
         6'h0F: begin
            d_op  = OP_SLL;
            d_x   = imm_zx;
            d_y   = LUI_SHIFT;
            d_ill = 1'b0;
            d_rd  = rt_f;
            d_wen = |rt_f;
         end
         6'h2B: begin
            d_op  = OP_ADD;
            d_y   = imm_sx;
            d_ill = 1'b0;
         end
         default: ;
      endcase
   end

   logic cap;

   assign in_ready = !out_valid || out_ready;
   assign cap      = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid   <= 1'b0;
         alu_x       <= '0;
         alu_y       <= '0;
         alu_op      <= 4'b0010;
         out_rd      <= '0;
         out_wen     <= 1'b0;
         out_illegal <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (cap) begin
         out_valid   <= 1'b1;
         alu_x       <= d_x;
         alu_y       <= d_y;
         alu_op      <= d_op;
         out_rd      <= d_rd;
         out_wen     <= d_wen;
         out_illegal <= d_ill;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed literal checks plus random traffic
// compared every cycle against a table-driven queue model.
module tb_alu_issue_stage;

   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic [3:0]  op;
      logic [4:0]  rd;
      logic        wen;
      logic        ill;
   } ent_t;

   localparam ent_t RST_ENT = '{x: 32'h0, y: 32'h0, op: 4'b0010,
                                rd: 5'd0, wen: 1'b0, ill: 1'b0};

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_rs_val;
   logic [31:0] in_rt_val;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] alu_x;
   logic [31:0] alu_y;
   logic [3:0]  alu_op;
   logic [4:0]  out_rd;
   logic        out_wen;
   logic        out_illegal;

   int n_chk  = 0;
   int n_fail = 0;

   int rtab[64];
   int itab[64];

   ent_t mq[$];
   ent_t md;
   bit   acc;
   ent_t ne;

   alu_issue_stage #(.XLEN(32), .ILLEGAL_OP(4'b0010)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .in_rs_val  (in_rs_val),
      .in_rt_val  (in_rt_val),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .alu_x      (alu_x),
      .alu_y      (alu_y),
      .alu_op     (alu_op),
      .out_rd     (out_rd),
      .out_wen    (out_wen),
      .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference decode straight from the opcode/funct tables.
   function automatic ent_t model(input logic [31:0] ins,
                                  input logic [31:0] rsv,
                                  input logic [31:0] rtv);
      ent_t e;
      int   opc;
      int   fn;
      logic [31:0] sx;
      logic [31:0] zx;
      opc = int'(ins[31:26]);
      fn  = int'(ins[5:0]);
      sx  = {{16{ins[15]}}, ins[15:0]};
      zx  = {16'h0, ins[15:0]};
      e = '{x: rsv, y: rtv, op: 4'b0010, rd: 5'd0, wen: 1'b0, ill: 1'b1};
      if (opc == 0) begin
         if (rtab[fn] >= 0) begin
            e.op  = 4'(rtab[fn]);
            e.ill = 1'b0;
            e.rd  = ins[15:11];
            e.wen = (ins[15:11] != 0);
            if (fn < 8) begin
               e.x = rtv;
               e.y = (fn < 4) ? 32'(ins[10:6]) : 32'(rsv[4:0]);
            end
         end
      end else if (itab[opc] >= 0) begin
         e.op  = 4'(itab[opc]);
         e.ill = 1'b0;
         if (opc == 4 || opc == 5) begin
            e.y = rtv;
         end else if (opc == 'h2B) begin
            e.y = sx;
         end else begin
            e.rd  = ins[20:16];
            e.wen = (ins[20:16] != 0);
            if (opc >= 'h0C && opc <= 'h0E) e.y = zx;
            else if (opc == 'h0F) begin
               e.x = zx;
               e.y = 32'd16;
            end else e.y = sx;
         end
      end
      return e;
   endfunction

   always @(posedge clk) begin
      acc = (mq.size() == 0) || out_ready;
      if (reset) begin
         mq.delete();
         md = RST_ENT;
      end else if (flush) begin
         mq.delete();
      end else begin
         if (mq.size() != 0 && out_ready) void'(mq.pop_front());
         if (in_valid && acc) begin
            ne = model(in_instr, in_rs_val, in_rt_val);
            mq.push_back(ne);
            md = ne;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      chk("m_valid", out_valid, (mq.size() != 0));
      chk("m_in_ready", in_ready, (mq.size() == 0) || out_ready);
      chk("m_x", alu_x, md.x);
      chk("m_y", alu_y, md.y);
      chk("m_op", alu_op, md.op);
      chk("m_rd", out_rd, md.rd);
      chk("m_wen", out_wen, md.wen);
      chk("m_ill", out_illegal, md.ill);
   end

   task automatic drive(input logic [31:0] ins, input logic [31:0] rsv,
                        input logic [31:0] rtv);
      in_instr  = ins;
      in_rs_val = rsv;
      in_rt_val = rtv;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      int k;
      int f;
      w = $urandom;
      k = $urandom_range(0, 9);
      if (k < 5) begin
         w[31:26] = 6'h00;
         if (k < 4) begin
            do f = $urandom_range(0, 63); while (rtab[f] < 0);
            w[5:0] = 6'(f);
         end
      end else if (k < 9) begin
         do f = $urandom_range(1, 63); while (itab[f] < 0);
         w[31:26] = 6'(f);
      end
      return w;
   endfunction

   initial begin
      foreach (rtab[i]) rtab[i] = -1;
      foreach (itab[i]) itab[i] = -1;
      rtab[0]  = 8;  rtab[2]  = 9;  rtab[3]  = 11;
      rtab[4]  = 8;  rtab[6]  = 9;  rtab[7]  = 11;
      rtab[32] = 2;  rtab[33] = 2;  rtab[34] = 6;  rtab[35] = 6;
      rtab[36] = 0;  rtab[37] = 1;  rtab[38] = 3;  rtab[39] = 4;
      rtab[42] = 7;  rtab[43] = 5;
      itab[4]  = 6;  itab[5]  = 6;  itab[8]  = 2;  itab[9]  = 2;
      itab[10] = 7;  itab[11] = 5;  itab[12] = 0;  itab[13] = 1;
      itab[14] = 3;  itab[15] = 8;  itab[35] = 2;  itab[43] = 2;
      md = RST_ENT;

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      drive(32'h0, 32'h0, 32'h0);
      @(negedge clk);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_op", alu_op, 4'b0010);
      chk("rst_in_ready", in_ready, 1'b1);

      reset = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      drive(32'h00221820, 32'd5, 32'd7);
      step();
      chk("add_valid", out_valid, 1'b1);
      chk("add_op", alu_op, 4'b0010);
      chk("add_x", alu_x, 32'd5);
      chk("add_y", alu_y, 32'd7);
      chk("add_rd", out_rd, 5'd3);
      chk("add_wen", out_wen, 1'b1);

      drive(32'h000520C3, 32'h0, 32'h80000000);
      step();
      chk("sra_op", alu_op, 4'b1011);
      chk("sra_x", alu_x, 32'h80000000);
      chk("sra_y", alu_y, 32'd3);
      drive(32'h00252007, 32'h23, 32'h80000000);
      step();
      chk("srav_op", alu_op, 4'b1011);
      chk("srav_y", alu_y, 32'd3);

      drive(32'h3C081234, 32'hDEADBEEF, 32'h0);
      step();
      chk("lui_op", alu_op, 4'b1000);
      chk("lui_x", alu_x, 32'h00001234);
      chk("lui_y", alu_y, 32'd16);
      chk("lui_rd", out_rd, 5'd8);
      drive(32'h3022FFFF, 32'h1, 32'h0);
      step();
      chk("andi_y", alu_y, 32'h0000FFFF);
      chk("andi_op", alu_op, 4'b0000);
      drive(32'h2022FFFF, 32'h1, 32'h0);
      step();
      chk("addi_y", alu_y, 32'hFFFFFFFF);

      drive(32'hFC000000, 32'h11, 32'h22);
      step();
      chk("ill_op", alu_op, 4'b0010);
      chk("ill_flag", out_illegal, 1'b1);
      chk("ill_wen", out_wen, 1'b0);
      chk("ill_rd", out_rd, 5'd0);
      chk("ill_y", alu_y, 32'h22);

      drive(32'h00221820, 32'd5, 32'd7);
      step();
      out_ready = 1'b0;
      drive(32'h00222822, 32'd9, 32'd4);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_in_ready", in_ready, 1'b0);
         chk("stall_valid", out_valid, 1'b1);
         chk("stall_x", alu_x, 32'd5);
         chk("stall_op", alu_op, 4'b0010);
      end
      out_ready = 1'b1;
      #1;
      chk("unstall_in_ready", in_ready, 1'b1);
      step();
      chk("nobubble_valid", out_valid, 1'b1);
      chk("nobubble_op", alu_op, 4'b0110);
      chk("nobubble_x", alu_x, 32'd9);
      chk("nobubble_rd", out_rd, 5'd5);

      flush = 1'b1;
      drive(32'h00221820, 32'd5, 32'd7);
      step();
      chk("flush_valid", out_valid, 1'b0);
      chk("flush_x", alu_x, 32'd9);
      flush = 1'b0; in_valid = 1'b0;
      step();
      chk("flush_idle", out_valid, 1'b0);

      in_valid = 1'b1;
      step();
      out_ready = 1'b0;
      drive(32'h3C081234, 32'h0, 32'h0);
      step();
      chk("pre_rst_valid", out_valid, 1'b1);
      chk("pre_rst_in_ready", in_ready, 1'b0);
      reset = 1'b1;
      step();
      chk("mid_rst_valid", out_valid, 1'b0);
      chk("mid_rst_x", alu_x, 32'h0);
      chk("mid_rst_y", alu_y, 32'h0);
      chk("mid_rst_op", alu_op, 4'b0010);
      chk("mid_rst_rd", out_rd, 5'd0);
      chk("mid_rst_wen", out_wen, 1'b0);
      chk("mid_rst_ill", out_illegal, 1'b0);
      chk("mid_rst_in_ready", in_ready, 1'b1);
      reset = 1'b0; in_valid = 1'b0;

      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         reset     = ($urandom_range(0, 99) < 2);
         flush     = ($urandom_range(0, 99) < 8);
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         drive(rand_instr(), $urandom, $urandom);
      end
      @(negedge clk);
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
